// File: rtl/id_rr_pkg.sv
// Shared widths and payload layout for the ID->RR pipeline register.
// Optional performance counters in the top are enabled with ID_RR_PR_PERF_CNT_EN.
package id_rr_pkg;

  localparam int PC_W   = 32;
  localparam int CTRL_W = 7;
  localparam int IDX_W  = 3;
  localparam int IMM_W  = 32;
  localparam int LEN_W  = 3;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [IDX_W-1:0]  src1;
    logic [IDX_W-1:0]  src2;
    logic [IMM_W-1:0]  imm;
    logic [LEN_W-1:0]  len;
    logic              valid;
  } id_rr_payload_t;

  localparam int PAYLOAD_W = $bits(id_rr_payload_t);

  // A bubble is an all-zero slot, so valid is cleared along with the payload.
  localparam id_rr_payload_t ID_RR_BUBBLE = '0;

endpackage

// File: rtl/id_rr_pipe_reg_field_reg.sv
// Generic W-bit pipeline flop with synchronous clear and hold.
// Clear has priority over hold, so a flush during a stall still yields a bubble.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d_in;
    if (clr) begin
      data_d = '0;
    end else if (hold) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q_out = data_q;

endmodule

// File: rtl/id_rr_pipe_reg.sv
// ID->RR pipeline register: one-cycle registered payload with stall (hold) and flush (bubble).
// Define ID_RR_PR_PERF_CNT_EN to add stall_cycles_out / flush_count_out counters.
module id_rr_pipe_reg
  import id_rr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [LEN_W-1:0]  instr_length_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [IDX_W-1:0]  src1_idx_in,
  input  logic [IDX_W-1:0]  src2_idx_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              valid_in,
`ifdef ID_RR_PR_PERF_CNT_EN
  output logic [31:0]       stall_cycles_out,
  output logic [31:0]       flush_count_out,
`endif
  output logic [PC_W-1:0]   pc_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [IDX_W-1:0]  src1_idx_out,
  output logic [IDX_W-1:0]  src2_idx_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [LEN_W-1:0]  instr_length_out,
  output logic              valid_out,
  output logic [IDX_W-1:0]  dst_idx
);

  id_rr_payload_t payload_in;
  id_rr_payload_t payload_out;
  logic [PAYLOAD_W-1:0] payload_bits;

  always_comb begin
    payload_in       = ID_RR_BUBBLE;
    payload_in.pc    = pc_in;
    payload_in.ctrl  = ctrl_in;
    payload_in.src1  = src1_idx_in;
    payload_in.src2  = src2_idx_in;
    payload_in.imm   = imm_in;
    payload_in.len   = instr_length_in;
    payload_in.valid = valid_in;
  end

  pipe_field_reg #(
    .W (PAYLOAD_W)
  ) u_payload_reg (
    .clk   (clk),
    .clr   (rst | flush),
    .hold  (stall),
    .d_in  (payload_in),
    .q_out (payload_bits)
  );

  assign payload_out      = id_rr_payload_t'(payload_bits);
  assign pc_out           = payload_out.pc;
  assign ctrl_out         = payload_out.ctrl;
  assign src1_idx_out     = payload_out.src1;
  assign src2_idx_out     = payload_out.src2;
  assign imm_out          = payload_out.imm;
  assign instr_length_out = payload_out.len;
  assign valid_out        = payload_out.valid;

  // Two-operand ISA: the destination is always the first source.
  assign dst_idx          = payload_out.src1;

`ifdef ID_RR_PR_PERF_CNT_EN
  logic [31:0] stall_cycles_d;
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_d;
  logic [31:0] flush_count_q;

  // A flushed edge is not a stalled edge, matching the payload priority.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (rst) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else if (flush) begin
      flush_count_d  = flush_count_q + 32'd1;
    end else if (stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  assign stall_cycles_out = stall_cycles_q;
  assign flush_count_out  = flush_count_q;
`endif

endmodule

// File: tb/tb_id_rr_pipe_reg.sv
// Directed self-checking bench for id_rr_pipe_reg (perf counters checked when
// ID_RR_PR_PERF_CNT_EN is defined).
module tb_id_rr_pipe_reg;
  import id_rr_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [LEN_W-1:0]  instr_length_in;
  logic [PC_W-1:0]   pc_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [IDX_W-1:0]  src1_idx_in;
  logic [IDX_W-1:0]  src2_idx_in;
  logic [IMM_W-1:0]  imm_in;
  logic              valid_in;
  logic [PC_W-1:0]   pc_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [IDX_W-1:0]  src1_idx_out;
  logic [IDX_W-1:0]  src2_idx_out;
  logic [IMM_W-1:0]  imm_out;
  logic [LEN_W-1:0]  instr_length_out;
  logic              valid_out;
  logic [IDX_W-1:0]  dst_idx;
`ifdef ID_RR_PR_PERF_CNT_EN
  logic [31:0]       stall_cycles_out;
  logic [31:0]       flush_count_out;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_rr_pipe_reg dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .instr_length_in  (instr_length_in),
    .pc_in            (pc_in),
    .ctrl_in          (ctrl_in),
    .src1_idx_in      (src1_idx_in),
    .src2_idx_in      (src2_idx_in),
    .imm_in           (imm_in),
    .valid_in         (valid_in),
`ifdef ID_RR_PR_PERF_CNT_EN
    .stall_cycles_out (stall_cycles_out),
    .flush_count_out  (flush_count_out),
`endif
    .pc_out           (pc_out),
    .ctrl_out         (ctrl_out),
    .src1_idx_out     (src1_idx_out),
    .src2_idx_out     (src2_idx_out),
    .imm_out          (imm_out),
    .instr_length_out (instr_length_out),
    .valid_out        (valid_out),
    .dst_idx          (dst_idx)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PC_W-1:0] pc, input logic [CTRL_W-1:0] ctrl,
                       input logic [IDX_W-1:0] s1, input logic [IDX_W-1:0] s2,
                       input logic [IMM_W-1:0] imm, input logic [LEN_W-1:0] len,
                       input logic vld);
    pc_in = pc; ctrl_in = ctrl; src1_idx_in = s1; src2_idx_in = s2;
    imm_in = imm; instr_length_in = len; valid_in = vld;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'h5555_5555, 7'h2A, 3'd3, 3'd4, 32'h1234, 3'd2, 1'b1);

    // Reset clears everything even with live inputs.
    step();
    check_val("rst_pc",    pc_out, 0);
    check_val("rst_ctrl",  ctrl_out, 0);
    check_val("rst_src1",  src1_idx_out, 0);
    check_val("rst_src2",  src2_idx_out, 0);
    check_val("rst_imm",   imm_out, 0);
    check_val("rst_len",   instr_length_out, 0);
    check_val("rst_valid", valid_out, 0);
    check_val("rst_dst",   dst_idx, 0);

    // Load
    rst = 1'b0;
    drive(32'h1234_5678, 7'b1010101, 3'd1, 3'd2, 32'hFFFF_FFFF, 3'd5, 1'b1);
    step();
    check_val("ld_pc",    pc_out, 32'h1234_5678);
    check_val("ld_ctrl",  ctrl_out, 7'b1010101);
    check_val("ld_src1",  src1_idx_out, 1);
    check_val("ld_src2",  src2_idx_out, 2);
    check_val("ld_imm",   imm_out, 32'hFFFF_FFFF);
    check_val("ld_len",   instr_length_out, 5);
    check_val("ld_valid", valid_out, 1);
    check_val("ld_dst",   dst_idx, 1);

    // Stall holds across two edges despite changed inputs
    stall = 1'b1;
    drive(32'hDEAD_BEEF, 7'd0, 3'd7, 3'd5, 32'h0, 3'd1, 1'b0);
    step();
    step();
    check_val("st_pc",    pc_out, 32'h1234_5678);
    check_val("st_ctrl",  ctrl_out, 7'b1010101);
    check_val("st_valid", valid_out, 1);
    check_val("st_imm",   imm_out, 32'hFFFF_FFFF);
    check_val("st_dst",   dst_idx, 1);

    // Flush alone
    stall = 1'b0; flush = 1'b1;
    drive(32'h9999_9999, 7'h7F, 3'd5, 3'd6, 32'hABCD, 3'd4, 1'b1);
    step();
    check_val("fl_pc",    pc_out, 0);
    check_val("fl_valid", valid_out, 0);
    check_val("fl_ctrl",  ctrl_out, 0);
    check_val("fl_dst",   dst_idx, 0);

    // Reload, then flush together with stall: flush wins
    flush = 1'b0;
    drive(32'h0000_0BAD, 7'h11, 3'd4, 3'd3, 32'h77, 3'd3, 1'b1);
    step();
    check_val("rl_pc", pc_out, 32'h0000_0BAD);
    flush = 1'b1; stall = 1'b1;
    drive(32'h9999_9999, 7'h7F, 3'd5, 3'd6, 32'hABCD, 3'd4, 1'b1);
    step();
    check_val("flst_pc",    pc_out, 0);
    check_val("flst_valid", valid_out, 0);
    check_val("flst_imm",   imm_out, 0);

    // Release loads the inputs present at the next edge
    flush = 1'b0; stall = 1'b0;
    drive(32'h0000_00A0, 7'h05, 3'd6, 3'd1, 32'h10, 3'd2, 1'b1);
    step();
    check_val("rel_pc",  pc_out, 32'hA0);
    check_val("rel_dst", dst_idx, 6);
    check_val("rel_src2", src2_idx_out, 1);

    // Reset during a stall clears and ignores the stall
    stall = 1'b1; rst = 1'b1;
    step();
    check_val("rst_st_pc",    pc_out, 0);
    check_val("rst_st_valid", valid_out, 0);
    rst = 1'b0;
    step();
    check_val("rst_st_hold_pc", pc_out, 0);
    stall = 1'b0;
    drive(32'h0000_0C0C, 7'h01, 3'd2, 3'd7, 32'h5, 3'd6, 1'b0);
    step();
    check_val("nv_pc",    pc_out, 32'h0C0C);
    check_val("nv_len",   instr_length_out, 6);
    check_val("nv_valid", valid_out, 0);

`ifdef ID_RR_PR_PERF_CNT_EN
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    check_val("pc_rst_stall", stall_cycles_out, 0);
    check_val("pc_rst_flush", flush_count_out, 0);
    rst = 1'b0; flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b1; stall = 1'b0;
    step();
    stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    step();
    check_val("pc_stall_cycles", stall_cycles_out, 3);
    check_val("pc_flush_count",  flush_count_out, 2);
    rst = 1'b1;
    step();
    check_val("pc_clr_stall", stall_cycles_out, 0);
    check_val("pc_clr_flush", flush_count_out, 0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
